// File: rtl/time_set_controller.sv
// Time-set sequencer: captures live time, edits hours then minutes, commits with a load strobe.
// Define TIMEOUT_EN to abandon an idle edit after TIMEOUT_CYCLES with a one-cycle abort strobe.
module time_set_controller #(
  parameter int BLINK_HALF     = 25_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int CNT_W          = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_tick,
  input  logic       up_tick,
  input  logic       down_tick,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       set_active,
  output logic [4:0] hours_out,
  output logic [5:0] minutes_out,
  output logic       load_pulse,
  output logic       blank_hours,
  output logic       blank_minutes,
  output logic       abort_pulse
);

  if (BLINK_HALF < 2 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("BLINK_HALF and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       hours_q, hours_d;
  logic [5:0]       minutes_q, minutes_d;
  logic [CNT_W-1:0] blink_q, blink_d;
  logic             phase_q, phase_d;
  logic             set_active_q, set_active_d;
  logic             load_q, load_d;
  logic             blank_h_q, blank_h_d;
  logic             blank_m_q, blank_m_d;
  logic             abort_q, abort_d;
  logic             adj;
  logic             in_set;
  logic             timeout;
`ifdef TIMEOUT_EN
  logic [CNT_W-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d   = state_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    blink_d   = '0;
    phase_d   = 1'b0;
    abort_d   = 1'b0;
    timeout   = 1'b0;
    adj       = up_tick ^ down_tick;
    in_set    = (state_q == SET_HR) || (state_q == SET_MIN);
`ifdef TIMEOUT_EN
    idle_d = '0;
    if (in_set && !mode_tick && !up_tick && !down_tick) begin
      if (idle_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else idle_d = idle_q + CNT_W'(1);
    end
`endif
    unique case (state_q)
      RUN: begin
        if (mode_tick) begin
          state_d   = SET_HR;
          hours_d   = cur_hours;
          minutes_d = cur_minutes;
        end
      end
      SET_HR: begin
        if (mode_tick) begin
          state_d = SET_MIN;
        end else if (timeout) begin
          state_d = RUN;
          abort_d = 1'b1;
        end else if (adj) begin
          if (up_tick)
            hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
          else
            hours_d = (hours_q == 5'd0) ? 5'd23 : hours_q - 5'd1;
        end
      end
      SET_MIN: begin
        if (mode_tick) begin
          state_d = COMMIT;
        end else if (timeout) begin
          state_d = RUN;
          abort_d = 1'b1;
        end else if (adj) begin
          if (up_tick)
            minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
          else
            minutes_d = (minutes_q == 6'd0) ? 6'd59 : minutes_q - 6'd1;
        end
      end
      COMMIT: state_d = RUN;
      default: state_d = RUN;
    endcase

    // Blink restarts (shown) on entry and on every accepted edit
    if (in_set && !mode_tick && !timeout && !adj) begin
      if (blink_q == CNT_W'(BLINK_HALF - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + CNT_W'(1);
        phase_d = phase_q;
      end
    end

    set_active_d = (state_d != RUN);
    load_d       = (state_d == COMMIT);
    blank_h_d    = (state_d == SET_HR) && phase_d;
    blank_m_d    = (state_d == SET_MIN) && phase_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      hours_q      <= '0;
      minutes_q    <= '0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      set_active_q <= 1'b0;
      load_q       <= 1'b0;
      blank_h_q    <= 1'b0;
      blank_m_q    <= 1'b0;
      abort_q      <= 1'b0;
`ifdef TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      set_active_q <= set_active_d;
      load_q       <= load_d;
      blank_h_q    <= blank_h_d;
      blank_m_q    <= blank_m_d;
      abort_q      <= abort_d;
`ifdef TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign set_active    = set_active_q;
  assign hours_out     = hours_q;
  assign minutes_out   = minutes_q;
  assign load_pulse    = load_q;
  assign blank_hours   = blank_h_q;
  assign blank_minutes = blank_m_q;
  assign abort_pulse   = abort_q;

endmodule
